// File: rtl/ibis_light_sequencer_if.sv
// ibis_light_sequencer_if
// Bundles every non-clock/reset signal of the light sequencer:
//   - frame control: start, cfg_* (frame size, light origin, attenuation)
//   - source pixel stream: src_valid/src_ready, src_value0/1
//   - lighting unit link: lt_enable, lt_write_registers, lt_x/lt_y,
//     lt_origin_x/y, lt_attenuation, lt_value0/1, lt_value_out, lt_ready
//   - result stream: m_valid/m_ready, m_data, m_last
//   - status: busy, done
// Modport slave is the sequencer's view; master is the surrounding
// environment (frame controller, pixel source, lighting unit, sink).
interface ibis_light_sequencer_if #(
  parameter int WIDTH = 11
);
  logic             start;
  logic [WIDTH-1:0] cfg_width;
  logic [WIDTH-1:0] cfg_height;
  logic [3:0]       cfg_attenuation;
  logic [WIDTH-1:0] cfg_origin_x;
  logic [WIDTH-1:0] cfg_origin_y;
  logic             src_valid;
  logic             src_ready;
  logic [7:0]       src_value0;
  logic [7:0]       src_value1;
  logic             lt_enable;
  logic [2:0]       lt_write_registers;
  logic [WIDTH-1:0] lt_x;
  logic [WIDTH-1:0] lt_y;
  logic [WIDTH-1:0] lt_origin_x;
  logic [WIDTH-1:0] lt_origin_y;
  logic [3:0]       lt_attenuation;
  logic [7:0]       lt_value0;
  logic [7:0]       lt_value1;
  logic [7:0]       lt_value_out;
  logic             lt_ready;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       m_data;
  logic             m_last;
  logic             busy;
  logic             done;

  modport slave (
    input  start, cfg_width, cfg_height, cfg_attenuation, cfg_origin_x,
           cfg_origin_y, src_valid, src_value0, src_value1, lt_value_out,
           lt_ready, m_ready,
    output src_ready, lt_enable, lt_write_registers, lt_x, lt_y,
           lt_origin_x, lt_origin_y, lt_attenuation, lt_value0, lt_value1,
           m_valid, m_data, m_last, busy, done
  );

  modport master (
    output start, cfg_width, cfg_height, cfg_attenuation, cfg_origin_x,
           cfg_origin_y, src_valid, src_value0, src_value1, lt_value_out,
           lt_ready, m_ready,
    input  src_ready, lt_enable, lt_write_registers, lt_x, lt_y,
           lt_origin_x, lt_origin_y, lt_attenuation, lt_value0, lt_value1,
           m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/ibis_light_sequencer.sv
// ibis_light_sequencer
// Walks a frame in raster order, feeding one source pixel at a time into a
// ten-phase lighting unit and streaming each result out on m_*.
// Ports:
//   aclk     - clock, rising edge
//   aresetn  - async active-low reset, shared with the lighting unit
//   bus      - ibis_light_sequencer_if.slave (control, source, lighting
//              unit link, result stream, status)
//
// state  | meaning
// S_IDLE | waiting for start; lt_enable held low
// S_RUN  | frame active; pixels accepted at p=0, results captured after p=9
module ibis_light_sequencer #(
  parameter int WIDTH = 11
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  ibis_light_sequencer_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [3:0]       r_p;
  logic [WIDTH-1:0] r_x, r_y;
  logic [WIDTH-1:0] r_cfg_w, r_cfg_h, r_org_x, r_org_y;
  logic [3:0]       r_att;
  logic             r_first;
  logic             r_remain;
  logic             r_last_op;
  logic             r_cap_pend;
  logic             r_m_valid, r_m_last, r_done, r_busy;
  logic [7:0]       r_m_data;

  logic w_run, w_lt_enable, w_accept, w_x_end, w_y_end;

  assign w_run   = (r_state == S_RUN);
  assign w_x_end = (r_x == r_cfg_w - WIDTH'(1));
  assign w_y_end = (r_y == r_cfg_h - WIDTH'(1));

  // p mirrors the lighting unit's one-hot phase; p=9 stalls while an
  // unconsumed result still occupies the output register.
  always_comb begin
    w_lt_enable = 1'b0;
    if (w_run) begin
      if (r_p == 4'd0)      w_lt_enable = bus.src_valid & r_remain;
      else if (r_p == 4'd9) w_lt_enable = ~r_m_valid | bus.m_ready;
      else                  w_lt_enable = 1'b1;
    end
  end

  assign w_accept = w_lt_enable & (r_p == 4'd0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= S_IDLE;
      r_p        <= 4'd0;
      r_x        <= '0;
      r_y        <= '0;
      r_cfg_w    <= '0;
      r_cfg_h    <= '0;
      r_org_x    <= '0;
      r_org_y    <= '0;
      r_att      <= 4'd0;
      r_first    <= 1'b0;
      r_remain   <= 1'b0;
      r_last_op  <= 1'b0;
      r_cap_pend <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= 8'd0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_cap_pend <= w_lt_enable & (r_p == 4'd9);
      if (w_lt_enable) r_p <= (r_p == 4'd9) ? 4'd0 : r_p + 4'd1;

      // A capture always lands on an empty output register: p=9 only
      // advanced if the previous beat was absent or consumed.
      if (r_cap_pend) begin
        r_m_valid <= 1'b1;
        r_m_data  <= bus.lt_value_out;
        r_m_last  <= r_last_op;
      end else if (bus.m_ready) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if ((bus.cfg_width != '0) && (bus.cfg_height != '0)) begin
              r_cfg_w   <= bus.cfg_width;
              r_cfg_h   <= bus.cfg_height;
              r_org_x   <= bus.cfg_origin_x;
              r_org_y   <= bus.cfg_origin_y;
              r_att     <= bus.cfg_attenuation;
              r_x       <= '0;
              r_y       <= '0;
              r_first   <= 1'b1;
              r_remain  <= 1'b1;
              r_last_op <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_first   <= 1'b0;
            r_last_op <= w_x_end & w_y_end;
            if (w_x_end) begin
              r_x <= '0;
              r_y <= r_y + WIDTH'(1);
              if (w_y_end) r_remain <= 1'b0;
            end else begin
              r_x <= r_x + WIDTH'(1);
            end
          end
          if (r_cap_pend && r_last_op) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.lt_enable          = w_lt_enable;
  assign bus.src_ready          = w_accept;
  assign bus.lt_write_registers = {3{w_accept & r_first}};
  assign bus.lt_x               = r_x;
  assign bus.lt_y               = r_y;
  assign bus.lt_origin_x        = r_org_x;
  assign bus.lt_origin_y        = r_org_y;
  assign bus.lt_attenuation     = r_att;
  assign bus.lt_value0          = bus.src_value0;
  assign bus.lt_value1          = bus.src_value1;
  assign bus.m_valid            = r_m_valid;
  assign bus.m_data             = r_m_data;
  assign bus.m_last             = r_m_last;
  assign bus.done               = r_done;
  assign bus.busy               = r_busy;

  // lt_ready is only a cross-check that both phase trackers agree.
  a_lt_ready_phase: assert property (@(posedge aclk) disable iff (!aresetn)
    bus.lt_ready == (r_p == 4'd9));

endmodule

// File: doc/ibis_light_sequencer.md
IBIS_LIGHT_SEQUENCER -- requirements
Module: ibis_light_sequencer

Interface
REQ-001 Parameter: WIDTH, 11, coordinate width in bits.
REQ-002 aclk  in  1  sole clock, all state updates on rising edge.
REQ-003 aresetn  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  frame start pulse, honoured only in IDLE.
REQ-005 cfg_width, cfg_height  in  WIDTH each  frame size in pixels.
REQ-006 cfg_attenuation, cfg_origin_x, cfg_origin_y  in  4 / WIDTH / WIDTH  light config.
REQ-007 src_valid, src_ready  in / out  1 each  source pixel handshake.
REQ-008 src_value0, src_value1  in  8 each  source components.
REQ-009 lt_enable, lt_write_registers  out  1 / 3  lighting unit advance and config-write strobes.
REQ-010 lt_x, lt_y, lt_origin_x, lt_origin_y  out  WIDTH each  to lighting unit.
REQ-011 lt_attenuation, lt_value0, lt_value1  out  4 / 8 / 8  to lighting unit.
REQ-012 lt_value_out, lt_ready  in  8 / 1  result and phase-9 flag from the lighting unit.
REQ-013 m_valid, m_ready, m_data, m_last  out / in / out / out  1/1/8/1  result stream.
REQ-014 busy, done  out  1 each  frame active; one-cycle frame-complete pulse.

Function
REQ-015 Two FSM states SHALL exist: IDLE and RUN.
REQ-016 In IDLE, start with cfg_width and cfg_height both nonzero SHALL latch all cfg_* inputs, clear x/y counters, set a first flag, and enter RUN.
REQ-017 start with either size zero SHALL pulse done on the next cycle and remain IDLE.
REQ-018 start SHALL be ignored in RUN.
REQ-019 A phase counter p (0..9) SHALL increment mod 10 on every cycle with lt_enable=1, mirroring the lighting unit's one-hot state.
REQ-020 lt_enable conditions: p=0 -> RUN & src_valid & pixels remain; p=1..8 -> 1; p=9 -> !m_valid | m_ready.
REQ-021 In IDLE, lt_enable SHALL be 0.
REQ-022 src_ready SHALL equal lt_enable & (p=0); lt_value0/1 SHALL pass src_value0/1 combinationally.
REQ-023 lt_x/lt_y SHALL show the current counters.
REQ-024 lt_origin_x, lt_origin_y and lt_attenuation SHALL show the latched config.
REQ-025 lt_write_registers SHALL be 3'b111 on the first accepted pixel of a frame and 3'b000 otherwise.
REQ-026 Scan order SHALL be raster: x increments per accepted pixel; at cfg_width-1 it wraps to 0 and y increments.
REQ-027 Accepting pixel (cfg_width-1, cfg_height-1) SHALL mark the last in-flight op and stop further acceptance.
REQ-028 A capture pending flag SHALL set on p=9 & lt_enable.
REQ-029 The cycle after the pending flag sets, lt_value_out SHALL be registered into m_data, with m_valid=1 and m_last copied from the in-flight last marker.
REQ-030 m_valid SHALL clear on m_ready when no capture occurs that cycle; m_data/m_last SHALL hold while m_valid & !m_ready.
REQ-031 Latency: pixel accepted in cycle T with no stalls -> m_valid high from T+11; the next pixel SHALL be acceptable in T+10.
REQ-032 Throughput: 1 pixel per 10 cycles maximum.
REQ-033 Capture of the last result SHALL pulse done for one cycle and return to IDLE; busy=1 exactly in RUN.
REQ-034 lt_ready SHALL be used only for an assertion that it is high exactly when p=9, never for control.

Reset
REQ-035 aresetn low SHALL force IDLE, p=0, and clear flags, counters and config registers.
REQ-036 During reset all outputs SHALL be 0: m_valid, m_last, m_data, done, busy, src_ready, lt_enable, lt_write_registers.
REQ-037 aresetn SHALL be shared with the lighting unit so both phase trackers restart at 0.
REQ-038 Reset mid-frame SHALL drop in-flight work with no output beat.

Verification (bench instantiates the real lighting unit; cfg_attenuation=4'hF so the result equals value1)
REQ-039 Reset: hold aresetn low 5 cycles -> all outputs 0; lt_enable stays 0 for 20 cycles after release.
REQ-040 2x2 frame, src_value1=0x10,0x20,0x30,0x40, src_valid=1, m_ready=1 -> src_ready at T, T+10, T+20, T+30.
REQ-041 Same 2x2 frame -> (x,y)=(0,0),(1,0),(0,1),(1,1); write_registers 111 only at T; m_data 10,20,30,40; m_last and done on the 4th beat.
REQ-042 Backpressure: m_ready=0 after first beat -> lt_enable low at p=9 of op 2; m_data holds 0x10; m_ready=1 -> resumes, no loss.
REQ-043 Source gap: src_valid low 7 cycles at p=0 -> lt_enable and src_ready low; p frozen; processing resumes on src_valid.
REQ-044 Zero size: cfg_width=0 with start -> done next cycle; no src_ready or lt_enable.
REQ-045 Mid-frame reset at p=5 -> no m_valid; a new 1x1 frame then returns the correct value.
